mux16_rr_arbiter: RTL

Round-robin arbiter and sequencer for the 16:1 single-bit multiplexer datapath. Sixteen requesters each own one mux input bit. The block grants them one at a time, drives the 4-bit mux select for the grant window, and registers the selected bit with a valid strobe. It sits directly in front of `mux16_1` and owns its select lines; the mux itself is instantiated inside this block.

---
 rtl/mux16_rr_arbiter_if.sv | 32 +++
 rtl/mux16_rr_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/mux16_rr_arbiter_if.sv
// Bus bundle between the round-robin arbiter and the logic that uses it.
// The master side drives requests and mux data; the slave side (the arbiter)
// returns the select, the one-hot grant and the registered sample.
interface mux16_rr_arbiter_if;
    logic [15:0] req;
    logic [15:0] in;
    logic [3:0]  s;
    logic [15:0] grant;
    logic        busy;
    logic        out;
    logic        out_valid;

    modport master (
        output req,
        output in,
        input  s,
        input  grant,
        input  busy,
        input  out,
        input  out_valid
    );

    modport slave (
        input  req,
        input  in,
        output s,
        output grant,
        output busy,
        output out,
        output out_valid
    );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// 16:1 single-bit mux plus the round-robin arbiter that owns its select lines.
// Requesters are granted one at a time for up to HOLD_CYCLES cycles; the
// selected bit is registered with a valid strobe while the grantee holds req.

module mux16_1 (
    input  logic [15:0] in,
    input  logic [3:0]  s,
    output logic        out
);
    // Plain combinational select.
    assign out = in[s];
endmodule

// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant outstanding; grant = 0, s keeps the last grantee index
// GRANT | one requester owns the mux; counter counts down the hold window
module mux16_rr_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux16_rr_arbiter_if.slave  bus
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic [3:0]    ptr;
    logic [CW-1:0] cnt;
    logic          mux_out;
    logic [3:0]    win;
    logic          win_vld;
    logic [3:0]    idx;
    logic          release_now;

    mux16_1 u_mux (
        .in  (bus.in),
        .s   (bus.s),
        .out (mux_out)
    );

    // First set request at or after ptr, wrapping 15 -> 0.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!win_vld && bus.req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    // Window ends when the grantee drops its request or the counter runs out.
    assign release_now = (state == GRANT) && (!bus.req[bus.s] || (cnt == '0));

    // Arbitration FSM with registered select, grant, busy and data sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            bus.s         <= '0;
            bus.grant     <= '0;
            bus.busy      <= 1'b0;
            bus.out       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (state == IDLE) begin
            bus.out_valid <= 1'b0;
            if (win_vld) begin
                state     <= GRANT;
                bus.s     <= win;
                bus.grant <= 16'h0001 << win;
                bus.busy  <= 1'b1;
                cnt       <= RELOAD;
                ptr       <= win + 4'd1;
            end
        end else begin
            if (bus.req[bus.s]) begin
                bus.out       <= mux_out;
                bus.out_valid <= 1'b1;
            end else begin
                bus.out_valid <= 1'b0;
            end
            if (release_now) begin
                // ptr already points past the current grantee, so it ranks last.
                if (win_vld) begin
                    bus.s     <= win;
                    bus.grant <= 16'h0001 << win;
                    cnt       <= RELOAD;
                    ptr       <= win + 4'd1;
                end else begin
                    state     <= IDLE;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                end
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule
